lsu_ctrl: RTL

//  Load/store controller between the pipeline MEM stage and the byte-addressed data memory (dm).

---
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory bus of the load/store controller.
// slave = the controller, master = MEM stage plus data memory.
interface lsu_ctrl_if #(parameter int ADDR_W = 6);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_type;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [2:0]        dm_type;
  logic [31:0]       dm_din;
  logic [31:0]       dm_dout;

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, resp_ready, dm_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_wr, dm_addr, dm_type, dm_din
  );

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, resp_ready, dm_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_wr, dm_addr, dm_type, dm_din
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller in front of the byte-addressed data memory.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned word/half accesses instead of passing them on.
module lsu_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);
  localparam int CW = ADDR_W + 3;
  localparam logic [CW-1:0] MEM_LIM = CW'(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, ERR, RESP} state_t;

  state_t            state, nxt;
  logic              req_ready_q, resp_valid_q, resp_err_q, dm_wr_q;
  logic [31:0]       resp_rdata_q, dm_din_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [2:0]        dm_type_q;

  logic              req_ready_d, resp_valid_d, resp_err_d, dm_wr_d;
  logic [31:0]       resp_rdata_d, dm_din_d;
  logic [ADDR_W-1:0] dm_addr_d;
  logic [2:0]        dm_type_d;

  logic [CW-1:0]     size, last;
  logic              misalign, chk_fail, accept;

  // Range check widened by 3 bits so addr+size cannot wrap past MEM_BYTES.
  always_comb begin
    case (bus.req_type)
      3'b000:        size = CW'(4);
      3'b001, 3'b010: size = CW'(2);
      default:       size = CW'(1);
    endcase
    last     = CW'(bus.req_addr[ADDR_W-1:0]) + size;
    misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misalign = ((bus.req_type == 3'b000) && (bus.req_addr[1:0] != 2'b00)) ||
               (((bus.req_type == 3'b001) || (bus.req_type == 3'b010)) && bus.req_addr[0]);
`endif
    chk_fail = (bus.req_type > 3'b100) ||
               (bus.req_we && ((bus.req_type == 3'b010) || (bus.req_type == 3'b100))) ||
               (|bus.req_addr[31:ADDR_W]) ||
               (last > MEM_LIM) ||
               misalign;
  end

  assign accept = (state == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      dm_wr_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_type_q    <= '0;
      dm_din_q     <= '0;
    end else begin
      state        <= nxt;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      dm_wr_q      <= dm_wr_d;
      dm_addr_q    <= dm_addr_d;
      dm_type_q    <= dm_type_d;
      dm_din_q     <= dm_din_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) nxt = chk_fail ? ERR : (bus.req_we ? WR : RD);
      WR:      nxt = RESP;
      RD:      nxt = CAP;
      CAP:     nxt = RESP;
      ERR:     nxt = RESP;
      RESP:    if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole state.
  always_comb begin
    req_ready_d  = (nxt == IDLE);
    resp_valid_d = (nxt == RESP);
    dm_wr_d      = (nxt == WR);
    dm_din_d     = (nxt == WR) ? bus.req_wdata : '0;
    dm_addr_d    = dm_addr_q;
    dm_type_d    = dm_type_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept && !chk_fail) begin
      dm_addr_d = bus.req_addr[ADDR_W-1:0];
      dm_type_d = bus.req_type;
    end
    if (accept) resp_rdata_d = '0;
    case (state)
      CAP:     resp_rdata_d = bus.dm_dout;
      ERR:     begin resp_rdata_d = '0; resp_err_d = 1'b1; end
      RESP:    if (bus.resp_ready) resp_err_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.dm_wr      = dm_wr_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_type    = dm_type_q;
  assign bus.dm_din     = dm_din_q;
endmodule
